// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter for the vga_adapter pixel port between two requesters,
// with a built-in full-screen clear sweep that pre-empts both requesters.
`timescale 1ns/1ps
module vga_plot_arbiter #(
  parameter int unsigned XW    = 8,
  parameter int unsigned YW    = 7,
  parameter int unsigned CW    = 3,
  parameter int unsigned X_MAX = 159,
  parameter int unsigned Y_MAX = 119
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  input  logic [CW-1:0] bg_colour,
  output logic          clear_busy,
  input  logic          req0_valid,
  input  logic [XW-1:0] req0_x,
  input  logic [YW-1:0] req0_y,
  input  logic [CW-1:0] req0_col,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [XW-1:0] req1_x,
  input  logic [YW-1:0] req1_y,
  input  logic [CW-1:0] req1_col,
  output logic          req1_ready,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state, state_d;
  logic          last;      // 1: requester 1 was granted most recently
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [CW-1:0] bg;
  logic          grant0, grant1;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic [CW-1:0] win_col;
  logic          in_range;
  logic          sweep_end;

  assign sweep_end = (cx == XW'(X_MAX)) && (cy == YW'(Y_MAX));

  // Next state and grant decode
  always_comb begin
    state_d = state;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state)
      ARB: begin
        if (clear_req) begin
          state_d = CLEAR;
        end else if (req0_valid && req1_valid) begin
          grant0 = last;
          grant1 = ~last;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
      CLEAR: begin
        if (sweep_end) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign win_x    = grant1 ? req1_x   : req0_x;
  assign win_y    = grant1 ? req1_y   : req0_y;
  assign win_col  = grant1 ? req1_col : req0_col;
  assign in_range = (win_x <= XW'(X_MAX)) && (win_y <= YW'(Y_MAX));

  // Readies are held low throughout reset, whatever the valids do
  assign req0_ready = grant0 & rst;
  assign req1_ready = grant1 & rst;
  assign clear_busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ARB;
      last   <= 1'b1;
      cx     <= '0;
      cy     <= '0;
      bg     <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      state <= state_d;
      plot  <= 1'b0;
      case (state)
        ARB: begin
          if (clear_req) begin
            cx <= '0;
            cy <= '0;
            bg <= bg_colour;
          end else if (grant0 || grant1) begin
            last <= grant1;
            if (in_range) begin
              x      <= win_x;
              y      <= win_y;
              colour <= win_col;
              plot   <= 1'b1;
            end
          end
        end
        CLEAR: begin
          x      <= cx;
          y      <= cy;
          colour <= bg;
          plot   <= 1'b1;
          if (cx == XW'(X_MAX)) begin
            cx <= '0;
            cy <= cy + YW'(1);
          end else begin
            cx <= cx + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed-vector bench for vga_plot_arbiter: reset, round-robin, streaming,
// out-of-range rejection, full clear sweep and reset during a clear.
`timescale 1ns/1ps
module tb_vga_plot_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_req;
  logic [2:0] bg_colour;
  logic       clear_busy;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_x, req1_x;
  logic [6:0] req0_y, req1_y;
  logic [2:0] req0_col, req1_col;
  logic       req0_ready, req1_ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vga_plot_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .bg_colour  (bg_colour),
    .clear_busy (clear_busy),
    .req0_valid (req0_valid),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_col   (req0_col),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_col   (req1_col),
    .req1_ready (req1_ready),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  task automatic check(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input int x0, input int y0, input int c0,
                       input logic v1, input int x1, input int y1, input int c1);
    req0_valid = v0; req0_x = 8'(x0); req0_y = 7'(y0); req0_col = 3'(c0);
    req1_valid = v1; req1_x = 8'(x1); req1_y = 7'(y1); req1_col = 3'(c1);
  endtask

  task automatic check_pix(input string tag, input int p, input int ex, input int ey, input int ec);
    check({tag, "_plot"}, int'(plot), p);
    check({tag, "_x"}, int'(x), ex);
    check({tag, "_y"}, int'(y), ey);
    check({tag, "_col"}, int'(colour), ec);
  endtask

  initial begin
    int rdy_bad;
    int busy_cnt;
    int pix_bad;
    int ex;
    int ey;
    rst = 1'b0;
    clear_req = 1'b0;
    bg_colour = 3'd0;
    drive(1'b1, 1, 1, 1, 1'b1, 2, 2, 2);
    #1;
    check("por_rdy0", int'(req0_ready), 0);
    check("por_rdy1", int'(req1_ready), 0);
    tick(); tick();
    check_pix("por", 0, 0, 0, 0);
    check("por_busy", int'(clear_busy), 0);
    rst = 1'b1;

    // Round-robin: both valid for four cycles, pointer starts at req1 so req0 wins first
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i, 10, 1, 1'b1, 50 + i, 11, 2);
      #1;
      check("rr_rdy0", int'(req0_ready), (i % 2 == 0) ? 1 : 0);
      check("rr_rdy1", int'(req1_ready), (i % 2 == 0) ? 0 : 1);
      tick();
      if (i % 2 == 0) check_pix("rr", 1, i, 10, 1);
      else            check_pix("rr", 1, 50 + i, 11, 2);
    end

    // Reset asserted mid-traffic clears everything without waiting for a clock
    drive(1'b1, 3, 3, 3, 1'b1, 4, 4, 4);
    #2;
    rst = 1'b0;
    #1;
    check_pix("rstmid", 0, 0, 0, 0);
    check("rstmid_rdy0", int'(req0_ready), 0);
    check("rstmid_rdy1", int'(req1_ready), 0);
    tick();
    rst = 1'b1;
    drive(1'b1, 10, 20, 5, 1'b0, 0, 0, 0);
    #1;
    check("post_rst_rdy0", int'(req0_ready), 1);
    check("post_rst_rdy1", int'(req1_ready), 0);
    tick();
    check_pix("post_rst", 1, 10, 20, 5);
    drive(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
    tick();
    check_pix("idle_hold", 0, 10, 20, 5);

    // req1 streaming alone, then a tie goes to req0
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 0, 0, 1'b1, i, 7, 4);
      #1;
      check("s1_rdy1", int'(req1_ready), 1);
      check("s1_rdy0", int'(req0_ready), 0);
      tick();
      check_pix("s1", 1, i, 7, 4);
    end
    drive(1'b1, 30, 30, 6, 1'b1, 31, 31, 1);
    #1;
    check("tie_rdy0", int'(req0_ready), 1);
    check("tie_rdy1", int'(req1_ready), 0);
    tick();
    check_pix("tie", 1, 30, 30, 6);

    // Out-of-range pixels are accepted but never plotted
    drive(1'b1, 160, 5, 3, 1'b0, 0, 0, 0);
    #1;
    check("oor_x_rdy", int'(req0_ready), 1);
    tick();
    check_pix("oor_x", 0, 30, 30, 6);
    drive(1'b1, 5, 120, 3, 1'b0, 0, 0, 0);
    #1;
    check("oor_y_rdy", int'(req0_ready), 1);
    tick();
    check_pix("oor_y", 0, 30, 30, 6);
    drive(1'b1, 1, 1, 1, 1'b1, 2, 2, 2);
    #1;
    check("oor_ptr_rdy1", int'(req1_ready), 1);
    check("oor_ptr_rdy0", int'(req0_ready), 0);
    tick();
    check_pix("oor_ptr", 1, 2, 2, 2);

    // Full clear with both requesters valid throughout
    drive(1'b1, 70, 70, 7, 1'b1, 71, 71, 1);
    clear_req = 1'b1;
    bg_colour = 3'd2;
    #1;
    check("clr_e0_rdy", int'(req0_ready | req1_ready), 0);
    tick();
    clear_req = 1'b0;
    check("clr_busy_e0", int'(clear_busy), 1);
    check("clr_plot_e0", int'(plot), 0);
    rdy_bad = 0;
    busy_cnt = 0;
    pix_bad = 0;
    for (int i = 1; i <= 19200; i++) begin
      if (req0_ready || req1_ready) rdy_bad++;
      if (clear_busy) busy_cnt++;
      if (i == 1000) bg_colour = 3'd5;
      tick();
      ex = (i - 1) % 160;
      ey = (i - 1) / 160;
      if (!(plot === 1'b1 && int'(x) == ex && int'(y) == ey && colour === 3'd2)) pix_bad++;
    end
    check("clr_rdy_cycles", rdy_bad, 0);
    check("clr_busy_cycles", busy_cnt, 19200);
    check("clr_bad_pixels", pix_bad, 0);
    check("clr_busy_end", int'(clear_busy), 0);
    check("clr_end_rdy0", int'(req0_ready), 1);
    check("clr_end_rdy1", int'(req1_ready), 0);
    tick();
    check_pix("clr_after", 1, 70, 70, 7);
    drive(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);

    // Reset while the sweep is at pixel (40,3)
    clear_req = 1'b1;
    bg_colour = 3'd6;
    tick();
    clear_req = 1'b0;
    for (int i = 1; i <= 521; i++) tick();
    check_pix("rclr_pre", 1, 40, 3, 6);
    check("rclr_busy_pre", int'(clear_busy), 1);
    rst = 1'b0;
    #1;
    check("rclr_busy", int'(clear_busy), 0);
    check("rclr_plot", int'(plot), 0);
    tick();
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b1, 9, 9, 3);
    #1;
    check("rclr_rdy1", int'(req1_ready), 1);
    tick();
    check_pix("rclr_acc", 1, 9, 9, 3);
    check("rclr_busy_after", int'(clear_busy), 0);
    drive(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
    tick(); tick();
    check("rclr_no_resume", int'(clear_busy), 0);
    check("rclr_idle_plot", int'(plot), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
